tron_seq_ctrl: RTL and testbench

Multi-cycle instruction sequencer for the 16-bit Tron datapath. It fetches an instruction, decodes the opcode and condition fields, and drives the write-back bus selector, register-file, flag, PC and data-memory controls. One instruction completes every 3 or more cycles. It sits between the instruction register and the datapath and is the only source of the bus select code.

---
 rtl/tron_ctrl_pkg.sv | 148 ++++++++++++++
 rtl/tron_cond_eval.sv | 42 ++++
 rtl/tron_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_tron_seq_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/tron_ctrl_pkg.sv
// Shared encodings for the Tron instruction sequencer: FSM states, opcode and
// ext fields, write-back bus select codes, PC source codes, condition codes,
// and the EXEC-state decode helper.
package tron_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM_RD = 3'd4,
    ST_MEM_WR = 3'd5,
    ST_LINK   = 3'd6
  } state_t;

  // Opcodes, instr[15:12]
  localparam logic [3:0] OP_RTYPE   = 4'b0000;
  localparam logic [3:0] OP_SPECIAL = 4'b0100;
  localparam logic [3:0] OP_SHIFT   = 4'b1000;
  localparam logic [3:0] OP_BCOND   = 4'b1100;
  localparam logic [3:0] OP_MOVI    = 4'b1101;
  localparam logic [3:0] OP_LUI     = 4'b1111;

  // Extended opcodes, instr[7:4]
  localparam logic [3:0] EXT_MOV    = 4'b1101;
  localparam logic [3:0] EXT_LOAD   = 4'b0000;
  localparam logic [3:0] EXT_STOR   = 4'b0100;
  localparam logic [3:0] EXT_JAL    = 4'b1000;
  localparam logic [3:0] EXT_JCOND  = 4'b1100;

  // Write-back bus select codes, shared with the bus mux
  localparam logic [2:0] BUS_ALU    = 3'b000;
  localparam logic [2:0] BUS_SHIFT  = 3'b001;
  localparam logic [2:0] BUS_IMM    = 3'b010;
  localparam logic [2:0] BUS_MEM    = 3'b011;
  localparam logic [2:0] BUS_PC     = 3'b100;
  localparam logic [2:0] BUS_REGB   = 3'b101;

  // PC source codes
  localparam logic [1:0] PC_INC     = 2'b00;
  localparam logic [1:0] PC_DISP    = 2'b01;
  localparam logic [1:0] PC_REGB    = 2'b10;

  // Condition codes, instr[11:8]
  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_HI = 4'b0100;
  localparam logic [3:0] CC_LS = 4'b0101;
  localparam logic [3:0] CC_GT = 4'b0110;
  localparam logic [3:0] CC_LE = 4'b0111;
  localparam logic [3:0] CC_FS = 4'b1000;
  localparam logic [3:0] CC_FC = 4'b1001;
  localparam logic [3:0] CC_LO = 4'b1010;
  localparam logic [3:0] CC_HS = 4'b1011;
  localparam logic [3:0] CC_LT = 4'b1100;
  localparam logic [3:0] CC_GE = 4'b1101;
  localparam logic [3:0] CC_UC = 4'b1110;
  localparam logic [3:0] CC_NV = 4'b1111;

  // Flag bit positions within flags[4:0] = {C,L,F,Z,N}
  localparam int FLG_C = 4;
  localparam int FLG_L = 3;
  localparam int FLG_F = 2;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 0;

  typedef enum logic [1:0] {
    NX_BOUNDARY = 2'd0,
    NX_MEM_RD   = 2'd1,
    NX_MEM_WR   = 2'd2,
    NX_LINK     = 2'd3
  } exec_next_t;

  typedef struct packed {
    logic [2:0] bus_sel;
    logic       reg_we;
    logic       flag_we;
    logic       alu_imm;
    logic       pc_en;
    logic [1:0] pc_src;
    exec_next_t nxt;
  } exec_ctl_t;

  // Controls driven during EXEC and where the FSM goes afterwards.
  function automatic exec_ctl_t exec_decode(input logic [15:0] instr,
                                            input logic        taken);
    exec_ctl_t  c;
    logic [3:0] op;
    logic [3:0] ext;
    op  = instr[15:12];
    ext = instr[7:4];
    c   = '{bus_sel: BUS_ALU, reg_we: 1'b0, flag_we: 1'b0, alu_imm: 1'b0,
            pc_en: 1'b0, pc_src: PC_INC, nxt: NX_BOUNDARY};
    case (op)
      OP_RTYPE: begin
        c.reg_we = 1'b1;
        c.pc_en  = 1'b1;
        if (ext == EXT_MOV) begin
          c.bus_sel = BUS_REGB;
        end else begin
          c.bus_sel = BUS_ALU;
          c.flag_we = 1'b1;
        end
      end
      OP_SHIFT: begin
        c.bus_sel = BUS_SHIFT;
        c.reg_we  = 1'b1;
        c.pc_en   = 1'b1;
      end
      OP_MOVI, OP_LUI: begin
        c.bus_sel = BUS_IMM;
        c.reg_we  = 1'b1;
        c.pc_en   = 1'b1;
      end
      OP_SPECIAL: begin
        case (ext)
          EXT_LOAD:  c.nxt = NX_MEM_RD;
          EXT_STOR:  c.nxt = NX_MEM_WR;
          EXT_JAL: begin
            // PC advances here so LINK can write PC+1 into the link register
            c.pc_en = 1'b1;
            c.nxt   = NX_LINK;
          end
          EXT_JCOND: begin
            c.pc_en  = 1'b1;
            c.pc_src = taken ? PC_REGB : PC_INC;
          end
          default:   c.pc_en = 1'b1;
        endcase
      end
      OP_BCOND: begin
        c.pc_en  = 1'b1;
        c.pc_src = taken ? PC_DISP : PC_INC;
      end
      default: begin
        c.alu_imm = 1'b1;
        c.bus_sel = BUS_ALU;
        c.reg_we  = 1'b1;
        c.flag_we = 1'b1;
        c.pc_en   = 1'b1;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tron_cond_eval.sv
// Condition evaluator shared by Jcond and Bcond: cond field + flags -> taken.
module tron_cond_eval
  import tron_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       taken
);

  logic c_f, l_f, f_f, z_f, n_f;

  assign c_f = flags[FLG_C];
  assign l_f = flags[FLG_L];
  assign f_f = flags[FLG_F];
  assign z_f = flags[FLG_Z];
  assign n_f = flags[FLG_N];

  // Evaluate the selected condition against the current flags
  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_EQ: taken = z_f;
      CC_NE: taken = ~z_f;
      CC_CS: taken = c_f;
      CC_CC: taken = ~c_f;
      CC_HI: taken = l_f;
      CC_LS: taken = ~l_f;
      CC_GT: taken = n_f;
      CC_LE: taken = ~n_f;
      CC_FS: taken = f_f;
      CC_FC: taken = ~f_f;
      CC_LO: taken = ~l_f & ~z_f;
      CC_HS: taken = l_f | z_f;
      CC_LT: taken = ~n_f & ~z_f;
      CC_GE: taken = n_f | z_f;
      CC_UC: taken = 1'b1;
      CC_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/tron_seq_ctrl.sv
// Multi-cycle instruction sequencer for the 16-bit Tron datapath.
//
// state  | meaning
// IDLE   | halted, all controls low; waits for run
// FETCH  | read instruction at PC; load IR on mem_ready
// DECODE | register file read, no strobes
// EXEC   | opcode-specific write-back / PC update
// MEM_RD | LOAD data read from regB address; write-back on mem_ready
// MEM_WR | STOR data write to regB address; done on mem_ready
// LINK   | JAL second half: write PC+1 to link register, jump to regB
module tron_seq_ctrl
  import tron_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] instr,
  input  logic [4:0]  flags,
  input  logic        mem_ready,
  output logic [2:0]  bus_sel,
  output logic        reg_we,
  output logic        flag_we,
  output logic        ir_we,
  output logic        alu_imm,
  output logic        pc_en,
  output logic [1:0]  pc_src,
  output logic        addr_sel,
  output logic        mem_re,
  output logic        mem_we,
  output logic [2:0]  state_dbg
);

  state_t    state;
  logic      taken;
  exec_ctl_t ectl;
  state_t    boundary_next;

  tron_cond_eval u_cond (
    .cond  (instr[11:8]),
    .flags (flags),
    .taken (taken)
  );

  assign ectl          = exec_decode(instr, taken);
  assign boundary_next = run ? ST_FETCH : ST_IDLE;
  assign state_dbg     = state;

  // Sequencer state register and transition logic
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (run) state <= ST_FETCH;
        ST_FETCH:  if (mem_ready) state <= ST_DECODE;
        ST_DECODE: state <= ST_EXEC;
        ST_EXEC: begin
          case (ectl.nxt)
            NX_MEM_RD: state <= ST_MEM_RD;
            NX_MEM_WR: state <= ST_MEM_WR;
            NX_LINK:   state <= ST_LINK;
            default:   state <= boundary_next;
          endcase
        end
        ST_MEM_RD: if (mem_ready) state <= boundary_next;
        ST_MEM_WR: if (mem_ready) state <= boundary_next;
        ST_LINK:   state <= boundary_next;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Datapath controls; reset gates everything so nothing leaks during reset
  always_comb begin
    bus_sel  = BUS_ALU;
    reg_we   = 1'b0;
    flag_we  = 1'b0;
    ir_we    = 1'b0;
    alu_imm  = 1'b0;
    pc_en    = 1'b0;
    pc_src   = PC_INC;
    addr_sel = 1'b0;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    if (!reset) begin
      case (state)
        ST_FETCH: begin
          mem_re = 1'b1;
          ir_we  = mem_ready;
        end
        ST_EXEC: begin
          bus_sel = ectl.bus_sel;
          reg_we  = ectl.reg_we;
          flag_we = ectl.flag_we;
          alu_imm = ectl.alu_imm;
          pc_en   = ectl.pc_en;
          pc_src  = ectl.pc_src;
        end
        ST_MEM_RD: begin
          mem_re   = 1'b1;
          addr_sel = 1'b1;
          bus_sel  = BUS_MEM;
          reg_we   = mem_ready;
          pc_en    = mem_ready;
        end
        ST_MEM_WR: begin
          mem_we   = 1'b1;
          addr_sel = 1'b1;
          pc_en    = mem_ready;
        end
        ST_LINK: begin
          bus_sel = BUS_PC;
          reg_we  = 1'b1;
          pc_en   = 1'b1;
          pc_src  = PC_REGB;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tron_seq_ctrl.sv
// Directed bench for tron_seq_ctrl: steps instructions through the sequencer
// and compares a packed control word against hand-computed expectations.
module tb_tron_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        run;
  logic [15:0] instr;
  logic [4:0]  flags;
  logic        mem_ready;
  logic [2:0]  bus_sel;
  logic        reg_we, flag_we, ir_we, alu_imm, pc_en;
  logic [1:0]  pc_src;
  logic        addr_sel, mem_re, mem_we;
  logic [2:0]  state_dbg;
  logic [15:0] obs;

  int n_cmp = 0;
  int n_bad = 0;

  tron_seq_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .instr     (instr),
    .flags     (flags),
    .mem_ready (mem_ready),
    .bus_sel   (bus_sel),
    .reg_we    (reg_we),
    .flag_we   (flag_we),
    .ir_we     (ir_we),
    .alu_imm   (alu_imm),
    .pc_en     (pc_en),
    .pc_src    (pc_src),
    .addr_sel  (addr_sel),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {state, bus_sel, reg_we, flag_we, ir_we, alu_imm, pc_en, pc_src, addr_sel, mem_re, mem_we}
  assign obs = {state_dbg, bus_sel, reg_we, flag_we, ir_we, alu_imm, pc_en,
                pc_src, addr_sel, mem_re, mem_we};

  function automatic logic [15:0] pk(input logic [2:0] st, input logic [2:0] bs,
                                     input logic rw, input logic fw, input logic iw,
                                     input logic ai, input logic pe, input logic [1:0] ps,
                                     input logic as, input logic re, input logic we);
    return {st, bs, rw, fw, iw, ai, pe, ps, as, re, we};
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %04h expected %04h (time %0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // From FETCH (mem_ready=1): check FETCH and DECODE, leave the DUT in EXEC.
  task automatic fd(input string tag, input logic [15:0] ins);
    instr = ins;
    #1;
    chk({tag, "_fetch"}, obs, pk(3'd1, 3'd0, 0, 0, 1, 0, 0, 2'd0, 0, 1, 0));
    step(); #1;
    chk({tag, "_decode"}, obs, pk(3'd2, 3'd0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0));
    step(); #1;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; instr = 16'h0000; flags = 5'b0; mem_ready = 1'b0;
    step(); step(); #1;
    chk("reset", obs, 16'h0000);
    reset = 1'b0; run = 1'b1; mem_ready = 1'b1;
    #1;
    chk("idle_run", obs, 16'h0000);
    step();

    fd("add", 16'h0251);
    chk("add_exec", obs, pk(3'd3, 3'd0, 1, 1, 0, 0, 1, 2'd0, 0, 0, 0));
    step();

    mem_ready = 1'b0; #1;
    chk("fetch_wait", obs, pk(3'd1, 3'd0, 0, 0, 0, 0, 0, 2'd0, 0, 1, 0));
    step(); #1;
    chk("fetch_hold", obs, pk(3'd1, 3'd0, 0, 0, 0, 0, 0, 2'd0, 0, 1, 0));
    mem_ready = 1'b1;

    fd("load", 16'h4302);
    chk("load_exec", obs, pk(3'd3, 3'd0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0));
    mem_ready = 1'b0;
    step(); #1;
    chk("load_w1", obs, pk(3'd4, 3'd3, 0, 0, 0, 0, 0, 2'd0, 1, 1, 0));
    step(); #1;
    chk("load_w2", obs, pk(3'd4, 3'd3, 0, 0, 0, 0, 0, 2'd0, 1, 1, 0));
    step(); mem_ready = 1'b1; #1;
    chk("load_done", obs, pk(3'd4, 3'd3, 1, 0, 0, 0, 1, 2'd0, 1, 1, 0));
    step();

    flags = 5'b00010;
    fd("beq_t", 16'hC0FE);
    chk("beq_taken", obs, pk(3'd3, 3'd0, 0, 0, 0, 0, 1, 2'd1, 0, 0, 0));
    step();
    flags = 5'b00000;
    fd("beq_n", 16'hC0FE);
    chk("beq_not", obs, pk(3'd3, 3'd0, 0, 0, 0, 0, 1, 2'd0, 0, 0, 0));
    step();
    flags = 5'b11111;
    fd("bnv", 16'hCFFE);
    chk("b_never", obs, pk(3'd3, 3'd0, 0, 0, 0, 0, 1, 2'd0, 0, 0, 0));
    step();
    flags = 5'b00000;
    fd("blo", 16'hCAFE);
    chk("blo_taken", obs, pk(3'd3, 3'd0, 0, 0, 0, 0, 1, 2'd1, 0, 0, 0));
    step();
    fd("bge", 16'hCDFE);
    chk("bge_not", obs, pk(3'd3, 3'd0, 0, 0, 0, 0, 1, 2'd0, 0, 0, 0));
    step();
    flags = 5'b01000;
    fd("bhs", 16'hCB10);
    chk("bhs_taken", obs, pk(3'd3, 3'd0, 0, 0, 0, 0, 1, 2'd1, 0, 0, 0));
    step();

    flags = 5'b00000;
    fd("jal", 16'h4E83);
    chk("jal_exec", obs, pk(3'd3, 3'd0, 0, 0, 0, 0, 1, 2'd0, 0, 0, 0));
    step(); #1;
    chk("jal_link", obs, pk(3'd6, 3'd4, 1, 0, 0, 0, 1, 2'd2, 0, 0, 0));
    step();

    fd("juc", 16'h4EC0);
    chk("juc_taken", obs, pk(3'd3, 3'd0, 0, 0, 0, 0, 1, 2'd2, 0, 0, 0));
    step();
    fd("jeq", 16'h40C0);
    chk("jeq_not", obs, pk(3'd3, 3'd0, 0, 0, 0, 0, 1, 2'd0, 0, 0, 0));
    step();

    fd("mov", 16'h00D1);
    chk("mov_exec", obs, pk(3'd3, 3'd5, 1, 0, 0, 0, 1, 2'd0, 0, 0, 0));
    step();
    fd("lui", 16'hF123);
    chk("lui_exec", obs, pk(3'd3, 3'd2, 1, 0, 0, 0, 1, 2'd0, 0, 0, 0));
    step();
    fd("movi", 16'hD123);
    chk("movi_exec", obs, pk(3'd3, 3'd2, 1, 0, 0, 0, 1, 2'd0, 0, 0, 0));
    step();
    fd("shift", 16'h8123);
    chk("shift_exec", obs, pk(3'd3, 3'd1, 1, 0, 0, 0, 1, 2'd0, 0, 0, 0));
    step();
    fd("addi", 16'h5123);
    chk("addi_exec", obs, pk(3'd3, 3'd0, 1, 1, 0, 1, 1, 2'd0, 0, 0, 0));
    step();
    fd("nop", 16'h4010);
    chk("nop_exec", obs, pk(3'd3, 3'd0, 0, 0, 0, 0, 1, 2'd0, 0, 0, 0));
    step();

    fd("stor", 16'h4342);
    chk("stor_exec", obs, pk(3'd3, 3'd0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0));
    step(); #1;
    chk("stor_done", obs, pk(3'd5, 3'd0, 0, 0, 0, 0, 1, 2'd0, 1, 0, 1));
    step();

    // run dropped during DECODE: instruction finishes then IDLE
    instr = 16'h0251; #1;
    chk("stop_fetch", obs, pk(3'd1, 3'd0, 0, 0, 1, 0, 0, 2'd0, 0, 1, 0));
    step(); run = 1'b0; #1;
    chk("stop_decode", obs, pk(3'd2, 3'd0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0));
    step(); #1;
    chk("stop_exec", obs, pk(3'd3, 3'd0, 1, 1, 0, 0, 1, 2'd0, 0, 0, 0));
    step(); #1;
    chk("stop_idle", obs, 16'h0000);
    step(); #1;
    chk("stop_idle2", obs, 16'h0000);
    run = 1'b1;
    step();

    // reset asserted while a store is waiting on memory
    fd("stor2", 16'h4342);
    mem_ready = 1'b0;
    step(); #1;
    chk("wr_wait", obs, pk(3'd5, 3'd0, 0, 0, 0, 0, 0, 2'd0, 1, 0, 1));
    reset = 1'b1; #1;
    chk("wr_reset", obs, 16'h0000);
    step(); #1;
    chk("wr_reset_hold", obs, 16'h0000);
    reset = 1'b0; mem_ready = 1'b1; #1;
    step(); #1;
    chk("post_reset_fetch", obs, pk(3'd1, 3'd0, 0, 0, 1, 0, 0, 2'd0, 0, 1, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
